// File: rtl/ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ifu_pkg;
  localparam int          ADDR_W           = 28;
  localparam int          DATA_W           = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_VALID = 2'd2
  } ifu_state_e;
endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter with next-PC selection: reset, redirect, advance by 4, or hold.
module ifu_pc_reg #(
  parameter logic [31:0] RESET_PC = ifu_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);
  import ifu_pkg::*;

  logic [31:0] pc_next;
  logic [1:0]  unused_redirect_bits;

  // Redirect targets are word aligned; the low two bits are ignored.
  assign unused_redirect_bits = redirect_pc[1:0];

  // NOTE: every path assigns pc_next first, so no latch can be inferred.
  always_comb begin
    pc_next = pc;
    if (reset)             pc_next = RESET_PC;
    else if (redirect_en)  pc_next = {redirect_pc[31:2], 2'b00};
    else if (advance)      pc_next = pc + PC_INCR;
  end

  always_ff @(posedge clk) begin
    pc <= pc_next;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, ROM request, instruction register, decode handshake.
// Define IFU_FETCH_COUNT_EN to add the fetchCount accepted-instruction counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = ifu_pkg::DEFAULT_RESET_PC,
  parameter int          ADDR_W   = ifu_pkg::ADDR_W,
  parameter int          DATA_W   = ifu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  output logic              readEn,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instrPc,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirectEn,
  input  logic [31:0]       redirectPc
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [31:0]       fetchCount
`endif
);
  import ifu_pkg::*;

  ifu_state_e        state, state_next;
  logic [31:0]       pc;
  logic              accept;
  logic [ADDR_W-1:0] addr_hold;
  logic              unused_pc_bits;

  assign accept         = instrValid && instrReady;
  assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redirectEn),
    .redirect_pc (redirectPc),
    .advance     (accept),
    .pc          (pc)
  );

  // NOTE: state is sequential, so it uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (reset) state <= IFU_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IFU_IDLE:  state_next = IFU_FETCH;
      IFU_FETCH: state_next = IFU_VALID;
      IFU_VALID: if (accept) state_next = IFU_FETCH;
      default:   state_next = IFU_IDLE;
    endcase
    if (redirectEn) state_next = IFU_FETCH;
  end

  always_comb begin
    readEn     = (state == IFU_FETCH);
    instrValid = (state == IFU_VALID);
  end

  // A redirect during FETCH discards the word read in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= '0;
      instrPc <= '0;
    end else if (state == IFU_FETCH && !redirectEn) begin
      instr   <= data;
      instrPc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   addr_hold <= '0;
    else if (state == IFU_FETCH) addr_hold <= pc[ADDR_W+1:2];
  end

  assign address = readEn ? pc[ADDR_W+1:2] : addr_hold;

`ifdef IFU_FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)       fetchCount <= '0;
    else if (accept) fetchCount <= fetchCount + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, wrap-around
// instance, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_PC = 0
  logic        reset_a, ready_a, redir_a;
  logic [31:0] redir_pc_a;
  logic [27:0] address_a;
  logic        read_en_a, valid_a;
  logic [31:0] data_a, instr_a, instr_pc_a;
  // Instance B: RESET_PC = 0xFFFF_FFFC
  logic        reset_b, ready_b, redir_b;
  logic [31:0] redir_pc_b;
  logic [27:0] address_b;
  logic        read_en_b, valid_b;
  logic [31:0] data_b, instr_b, instr_pc_b;
`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] count_a, count_b;
`endif

  // ROM word i holds i.
  assign data_a = {4'h0, address_a};
  assign data_b = {4'h0, address_b};

  instr_fetch_unit dut_a (
    .clk(clk), .reset(reset_a), .address(address_a), .readEn(read_en_a),
    .data(data_a), .instr(instr_a), .instrPc(instr_pc_a), .instrValid(valid_a),
    .instrReady(ready_a), .redirectEn(redir_a), .redirectPc(redir_pc_a)
`ifdef IFU_FETCH_COUNT_EN
    , .fetchCount(count_a)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b), .address(address_b), .readEn(read_en_b),
    .data(data_b), .instr(instr_b), .instrPc(instr_pc_b), .instrValid(valid_b),
    .instrReady(ready_b), .redirectEn(redir_b), .redirectPc(redir_pc_b)
`ifdef IFU_FETCH_COUNT_EN
    , .fetchCount(count_b)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rd;
    logic [27:0] e_addr;
    bit          e_val;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(bit rst, bit rdy, bit redir, logic [31:0] rpc,
                            bit e_rd, logic [27:0] e_addr, bit e_val,
                            logic [31:0] e_instr, logic [31:0] e_ipc);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.redir = redir; t.rpc = rpc;
    t.e_rd = e_rd; t.e_addr = e_addr; t.e_val = e_val;
    t.e_instr = e_instr; t.e_ipc = e_ipc;
    vecs.push_back(t);
  endfunction

  task automatic step_b(input bit rst, input bit rdy);
    reset_b = rst; ready_b = rdy;
    @(posedge clk); #1;
  endtask

  // Transaction-level model state for the random run.
  bit          m_fetch, m_held;
  logic [31:0] m_pc, m_hpc, m_hinstr, m_cnt;

  initial begin
    reset_a = 1'b1; ready_a = 1'b0; redir_a = 1'b0; redir_pc_a = '0;
    reset_b = 1'b1; ready_b = 1'b0; redir_b = 1'b0; redir_pc_b = '0;

    // rst rdy redir rpc        -> readEn address valid instr instrPc
    v(1, 1, 0, 0,          0, 28'h0,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          1, 28'h0,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          0, 28'h0,  1, 32'h0,  32'h0);
    v(0, 1, 0, 0,          1, 28'h1,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          0, 28'h1,  1, 32'h1,  32'h4);
    v(0, 1, 0, 0,          1, 28'h2,  0, 32'h1,  32'h4);
    v(0, 1, 0, 0,          0, 28'h2,  1, 32'h2,  32'h8);
    for (int i = 0; i < 5; i++) v(0, 0, 0, 0, 0, 28'h2, 1, 32'h2, 32'h8);
    v(0, 1, 0, 0,          1, 28'h3,  0, 32'h2,  32'h8);
    v(0, 0, 0, 0,          0, 28'h3,  1, 32'h3,  32'hC);
    v(0, 0, 1, 32'h103,    1, 28'h40, 0, 32'h3,  32'hC);
    v(0, 0, 0, 0,          0, 28'h40, 1, 32'h40, 32'h100);
    v(0, 1, 1, 32'h200,    1, 28'h80, 0, 32'h40, 32'h100);
    v(0, 0, 0, 0,          0, 28'h80, 1, 32'h80, 32'h200);
    v(1, 0, 0, 0,          0, 28'h0,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          1, 28'h0,  0, 32'h0,  32'h0);
    v(1, 1, 0, 0,          0, 28'h0,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          1, 28'h0,  0, 32'h0,  32'h0);
    v(0, 1, 0, 0,          0, 28'h0,  1, 32'h0,  32'h0);
    v(0, 1, 0, 0,          1, 28'h1,  0, 32'h0,  32'h0);
    v(0, 0, 1, 32'h300,    1, 28'hC0, 0, 32'h0,  32'h0);
    v(0, 0, 0, 0,          0, 28'hC0, 1, 32'hC0, 32'h300);
    v(1, 0, 0, 0,          0, 28'h0,  0, 32'h0,  32'h0);
    v(0, 0, 1, 32'h44,     1, 28'h11, 0, 32'h0,  32'h0);
    v(0, 0, 0, 0,          0, 28'h11, 1, 32'h11, 32'h44);
    v(0, 0, 0, 0,          0, 28'h11, 1, 32'h11, 32'h44);

    foreach (vecs[i]) begin
      reset_a = vecs[i].rst; ready_a = vecs[i].rdy;
      redir_a = vecs[i].redir; redir_pc_a = vecs[i].rpc;
      @(posedge clk); #1;
      check($sformatf("vec%0d readEn", i),     {31'b0, read_en_a}, {31'b0, vecs[i].e_rd});
      check($sformatf("vec%0d address", i),    {4'h0, address_a},  {4'h0, vecs[i].e_addr});
      check($sformatf("vec%0d instrValid", i), {31'b0, valid_a},   {31'b0, vecs[i].e_val});
      check($sformatf("vec%0d instr", i),      instr_a,            vecs[i].e_instr);
      check($sformatf("vec%0d instrPc", i),    instr_pc_a,         vecs[i].e_ipc);
    end

`ifdef IFU_FETCH_COUNT_EN
    // Counter: accept+redirect counts once, redirect alone does not.
    reset_a = 1'b1; redir_a = 1'b0; ready_a = 1'b0;
    @(posedge clk); #1;
    check("count reset", count_a, 32'd0);
    reset_a = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    ready_a = 1'b1; redir_a = 1'b1; redir_pc_a = 32'h200;
    @(posedge clk); #1;
    check("count accept+redirect", count_a, 32'd1);
    ready_a = 1'b0; redir_a = 1'b0;
    @(posedge clk); #1;
    redir_a = 1'b1; redir_pc_a = 32'h80;
    @(posedge clk); #1;
    redir_a = 1'b0;
    check("count redirect only", count_a, 32'd1);
`endif

    // Wrap-around on instance B.
    step_b(1, 0);
    check("wrap reset instrValid", {31'b0, valid_b}, 32'd0);
    step_b(0, 1);
    check("wrap first address", {4'h0, address_b}, 32'h0FFF_FFFF);
    step_b(0, 1);
    check("wrap first instrPc", instr_pc_b, 32'hFFFF_FFFC);
    check("wrap first instr", instr_b, 32'h0FFF_FFFF);
    step_b(0, 1);
    check("wrap next address", {4'h0, address_b}, 32'h0);
    check("wrap next readEn", {31'b0, read_en_b}, 32'd1);
    step_b(0, 0);
    check("wrap next instrPc", instr_pc_b, 32'h0);
    check("wrap next instr", instr_b, 32'h0);

    // Randomized run on instance A against the transaction-level model.
    for (int i = 0; i < 3000; i++) begin
      bit          rst, rdy, red;
      logic [31:0] rpc;
      rst = (i == 0) || ($urandom_range(49) == 0);
      rdy = ($urandom_range(3) != 0);
      red = ($urandom_range(7) == 0);
      rpc = $urandom;
      reset_a = rst; ready_a = rdy; redir_a = red; redir_pc_a = rpc;
      @(posedge clk);
      if (rst) begin
        m_pc = 32'h0; m_held = 1'b0; m_fetch = 1'b0; m_cnt = 32'h0;
      end else begin
        if (m_held && rdy) m_cnt = m_cnt + 32'd1;
        if (red) begin
          m_pc = {rpc[31:2], 2'b00}; m_held = 1'b0; m_fetch = 1'b1;
        end else if (m_fetch) begin
          m_held = 1'b1; m_fetch = 1'b0; m_hpc = m_pc; m_hinstr = {4'h0, m_pc[29:2]};
        end else if (m_held) begin
          if (rdy) begin m_pc = m_pc + 32'd4; m_held = 1'b0; m_fetch = 1'b1; end
        end else begin
          m_fetch = 1'b1;
        end
      end
      #1;
      check($sformatf("rand%0d readEn", i), {31'b0, read_en_a}, {31'b0, m_fetch});
      check($sformatf("rand%0d instrValid", i), {31'b0, valid_a}, {31'b0, m_held});
      if (m_fetch) check($sformatf("rand%0d address", i), {4'h0, address_a}, {4'h0, m_pc[29:2]});
      if (m_held) begin
        check($sformatf("rand%0d instr", i), instr_a, m_hinstr);
        check($sformatf("rand%0d instrPc", i), instr_pc_a, m_hpc);
      end
`ifdef IFU_FETCH_COUNT_EN
      check($sformatf("rand%0d fetchCount", i), count_a, m_cnt);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
